// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one uart_tx among N_REQ
// byte sources. Grants one byte per frame, launches it, follows the
// transmitter's tx_busy/tx_done handshake, then rotates priority.
// Optional build macro UART_SCHED_TIMEOUT_EN adds an ACK-phase watchdog
// that abandons a launch the transmitter never acknowledges.
module uart_tx_scheduler #(
   parameter int N_REQ       = 4,
   parameter int SRC_W       = 2,
   parameter int ACK_TIMEOUT = 31
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 en,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ*8-1:0]   req_data,
   output logic [N_REQ-1:0]     grant,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   input  logic                 tx_done,
   output logic                 active,
   output logic [SRC_W-1:0]     cur_src,
   output logic                 timeout_err
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LAUNCH = 2'd1;
   localparam logic [1:0] S_ACK    = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   if (N_REQ < 2 || SRC_W != $clog2(N_REQ) || ACK_TIMEOUT < 1) begin : g_bad_params
      $error("uart_tx_scheduler: illegal parameter combination");
   end

   logic [1:0]       state;
   logic [SRC_W-1:0] rr_ptr;
   logic [SRC_W-1:0] pick;
   logic             pick_vld;
   logic [SRC_W-1:0] next_src;
   logic [7:0]       data_arr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign data_arr[g] = req_data[8*g +: 8];
   end

   // Pointer that follows the owner of the frame being finished
   assign next_src = (cur_src == SRC_W'(N_REQ - 1)) ? '0 : cur_src + 1'b1;

`ifdef UART_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
   logic [CNT_W-1:0] ack_cnt;
   logic             ack_expired;

   assign ack_expired = !tx_busy && (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));

   // ACK watchdog: counts from 0 on ACK entry, latches a sticky error on expiry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ack_cnt     <= '0;
         timeout_err <= 1'b0;
      end else if (en) begin
         if (state == S_ACK) begin
            ack_cnt <= ack_cnt + 1'b1;
            if (ack_expired) timeout_err <= 1'b1;
         end else begin
            ack_cnt <= '0;
         end
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

   // First pending request at or above rr_ptr, wrapping past N_REQ-1
   always_comb begin
      int               idx;
      logic [SRC_W-1:0] idx_s;
      pick     = '0;
      pick_vld = 1'b0;
      idx      = 0;
      idx_s    = '0;
      for (int off = 0; off < N_REQ; off++) begin
         idx = int'(rr_ptr) + off;
         if (idx >= N_REQ) idx = idx - N_REQ;
         idx_s = SRC_W'(idx);
         if (!pick_vld && req[idx_s]) begin
            pick     = idx_s;
            pick_vld = 1'b1;
         end
      end
   end

   // Frame sequencer: grant/capture, launch, wait for busy, wait for completion
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         rr_ptr   <= '0;
         grant    <= '0;
         tx_start <= 1'b0;
         tx_data  <= '0;
         active   <= 1'b0;
         cur_src  <= '0;
      end else if (en) begin
         grant    <= '0;
         tx_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_vld && tx_done) begin
                  grant   <= N_REQ'(1) << pick;
                  tx_data <= data_arr[pick];
                  cur_src <= pick;
                  active  <= 1'b1;
                  state   <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               tx_start <= 1'b1;
               state    <= S_ACK;
            end
            S_ACK: begin
               if (tx_busy) begin
                  state <= S_DONE;
               end
`ifdef UART_SCHED_TIMEOUT_EN
               else if (ack_expired) begin
                  rr_ptr <= next_src;
                  active <= 1'b0;
                  state  <= S_IDLE;
               end
`endif
            end
            default: begin
               if (tx_done && !tx_busy) begin
                  rr_ptr <= next_src;
                  active <= 1'b0;
                  state  <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed testbench for uart_tx_scheduler. The transmitter handshake is
// played by the bench tasks; all expected values are hand-derived.
module tb_uart_tx_scheduler;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        en;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  grant;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        tx_done;
   logic        active;
   logic [1:0]  cur_src;
   logic        timeout_err;

   int vec_cnt = 0;
   int err_cnt = 0;

   uart_tx_scheduler #(.N_REQ(4), .SRC_W(2), .ACK_TIMEOUT(31)) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .req(req), .req_data(req_data),
      .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(tx_busy), .tx_done(tx_done), .active(active),
      .cur_src(cur_src), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Assert reset, check every output is cleared immediately, then release
   task automatic test_reset(input string tag);
      reset_n = 1'b0;
      #1;
      vec_cnt++; if (grant !== 4'b0000) begin err_cnt++; $display("FAIL %s grant: got %b expected 0000", tag, grant); end
      vec_cnt++; if (tx_start !== 1'b0) begin err_cnt++; $display("FAIL %s tx_start: got %b expected 0", tag, tx_start); end
      vec_cnt++; if (tx_data !== 8'h00) begin err_cnt++; $display("FAIL %s tx_data: got %h expected 00", tag, tx_data); end
      vec_cnt++; if (active !== 1'b0) begin err_cnt++; $display("FAIL %s active: got %b expected 0", tag, active); end
      vec_cnt++; if (cur_src !== 2'd0) begin err_cnt++; $display("FAIL %s cur_src: got %0d expected 0", tag, cur_src); end
      vec_cnt++; if (timeout_err !== 1'b0) begin err_cnt++; $display("FAIL %s timeout_err: got %b expected 0", tag, timeout_err); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // One complete frame from IDLE with the request already applied and tx_done=1
   task automatic serve_frame(input int src, input logic [7:0] data, input string tag);
      logic [3:0] g;
      g = 4'b0001 << src;
      @(negedge clk);
      vec_cnt++; if (grant !== g) begin err_cnt++; $display("FAIL %s grant: got %b expected %b", tag, grant, g); end
      vec_cnt++; if (tx_data !== data) begin err_cnt++; $display("FAIL %s tx_data: got %h expected %h", tag, tx_data, data); end
      vec_cnt++; if (cur_src !== 2'(src)) begin err_cnt++; $display("FAIL %s cur_src: got %0d expected %0d", tag, cur_src, src); end
      vec_cnt++; if (active !== 1'b1) begin err_cnt++; $display("FAIL %s active_grant: got %b expected 1", tag, active); end
      vec_cnt++; if (tx_start !== 1'b0) begin err_cnt++; $display("FAIL %s early_start: got %b expected 0", tag, tx_start); end
      @(negedge clk);
      vec_cnt++; if (tx_start !== 1'b1) begin err_cnt++; $display("FAIL %s tx_start: got %b expected 1", tag, tx_start); end
      vec_cnt++; if (grant !== 4'b0000) begin err_cnt++; $display("FAIL %s grant_pulse: got %b expected 0000", tag, grant); end
      tx_busy = 1'b1;
      tx_done = 1'b0;
      @(negedge clk);
      vec_cnt++; if (tx_start !== 1'b0) begin err_cnt++; $display("FAIL %s start_pulse: got %b expected 0", tag, tx_start); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vec_cnt++; if (active !== 1'b1 || tx_start !== 1'b0 || tx_data !== data) begin
            err_cnt++; $display("FAIL %s busy_phase: got active=%b start=%b data=%h expected 1 0 %h", tag, active, tx_start, tx_data, data);
         end
      end
      tx_busy = 1'b0;
      tx_done = 1'b1;
      @(negedge clk);
      vec_cnt++; if (active !== 1'b0 || grant !== 4'b0000) begin
         err_cnt++; $display("FAIL %s return_idle: got active=%b grant=%b expected 0 0000", tag, active, grant);
      end
   endtask

   task automatic test_single_request();
      req_data = 32'h0000_5A00;
      req = 4'b0010;
      serve_frame(1, 8'h5A, "single");
      // all requesting now: the rotated pointer (2) decides the winner
      req_data = 32'h4433_2211;
      req = 4'b1111;
      serve_frame(2, 8'h33, "single_ptr");
   endtask

   task automatic test_all_requesting();
      logic [7:0] exp_b [5];
      int         exp_s [5];
      exp_s = '{0, 1, 2, 3, 0};
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      req_data = 32'h4433_2211;
      req = 4'b1111;
      for (int f = 0; f < 5; f++) serve_frame(exp_s[f], exp_b[f], "all_req");
   endtask

   task automatic test_not_ready();
      req = 4'b0001;
      tx_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vec_cnt++; if (grant !== 4'b0000 || active !== 1'b0) begin
            err_cnt++; $display("FAIL not_ready_hold: got grant=%b active=%b expected 0000 0", grant, active);
         end
      end
      tx_done = 1'b1;
      serve_frame(0, 8'h11, "not_ready");
      req = 4'b0000;
   endtask

   task automatic test_enable_freeze();
      req_data = 32'h0077_0000;
      req = 4'b0100;
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vec_cnt++; if (grant !== 4'b0000) begin err_cnt++; $display("FAIL freeze_idle grant: got %b expected 0000", grant); end
      end
      en = 1'b1;
      @(negedge clk);
      vec_cnt++; if (grant !== 4'b0100 || tx_data !== 8'h77) begin
         err_cnt++; $display("FAIL freeze_grant: got grant=%b data=%h expected 0100 77", grant, tx_data);
      end
      req = 4'b0000;
      @(negedge clk);
      vec_cnt++; if (tx_start !== 1'b1) begin err_cnt++; $display("FAIL freeze_start: got %b expected 1", tx_start); end
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vec_cnt++; if (tx_start !== 1'b1 || active !== 1'b1 || tx_data !== 8'h77) begin
            err_cnt++; $display("FAIL freeze_hold: got start=%b active=%b data=%h expected 1 1 77", tx_start, active, tx_data);
         end
      end
      en = 1'b1;
      tx_busy = 1'b1;
      tx_done = 1'b0;
      @(negedge clk);
      vec_cnt++; if (tx_start !== 1'b0 || active !== 1'b1) begin
         err_cnt++; $display("FAIL freeze_resume: got start=%b active=%b expected 0 1", tx_start, active);
      end
      @(negedge clk);
      tx_busy = 1'b0;
      tx_done = 1'b1;
      @(negedge clk);
      vec_cnt++; if (active !== 1'b0) begin err_cnt++; $display("FAIL freeze_end active: got %b expected 0", active); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vec_cnt++; if (tx_start !== 1'b0 || grant !== 4'b0000) begin
            err_cnt++; $display("FAIL freeze_single_frame: got start=%b grant=%b expected 0 0000", tx_start, grant);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      req_data = 32'hC300_003C;
      req = 4'b0001;
      @(negedge clk);
      vec_cnt++; if (grant !== 4'b0001 || tx_data !== 8'h3C) begin
         err_cnt++; $display("FAIL midrst_grant: got grant=%b data=%h expected 0001 3c", grant, tx_data);
      end
      @(negedge clk);
      tx_busy = 1'b1;
      tx_done = 1'b0;
      repeat (2) @(negedge clk);
      vec_cnt++; if (active !== 1'b1) begin err_cnt++; $display("FAIL midrst_in_done active: got %b expected 1", active); end
      req = 4'b1000;
      test_reset("midrst");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vec_cnt++; if (grant !== 4'b0000 || active !== 1'b0) begin
            err_cnt++; $display("FAIL midrst_wait_done: got grant=%b active=%b expected 0000 0", grant, active);
         end
      end
      tx_busy = 1'b0;
      tx_done = 1'b1;
      serve_frame(3, 8'hC3, "midrst");
      req = 4'b0000;
   endtask

   task automatic test_ack_timeout();
      req_data = 32'h00B2_A100;
      req = 4'b0110;
      @(negedge clk);
      vec_cnt++; if (grant !== 4'b0010) begin err_cnt++; $display("FAIL timeout_grant1: got %b expected 0010", grant); end
      @(negedge clk);
      vec_cnt++; if (tx_start !== 1'b1) begin err_cnt++; $display("FAIL timeout_start: got %b expected 1", tx_start); end
`ifdef UART_SCHED_TIMEOUT_EN
      repeat (30) @(negedge clk);
      vec_cnt++; if (active !== 1'b1 || timeout_err !== 1'b0) begin
         err_cnt++; $display("FAIL timeout_early: got active=%b err=%b expected 1 0", active, timeout_err);
      end
      @(negedge clk);
      vec_cnt++; if (active !== 1'b0 || timeout_err !== 1'b1) begin
         err_cnt++; $display("FAIL timeout_fire: got active=%b err=%b expected 0 1", active, timeout_err);
      end
      @(negedge clk);
      vec_cnt++; if (grant !== 4'b0100 || tx_data !== 8'hB2 || timeout_err !== 1'b1) begin
         err_cnt++; $display("FAIL timeout_next: got grant=%b data=%h err=%b expected 0100 b2 1", grant, tx_data, timeout_err);
      end
`else
      repeat (40) @(negedge clk);
      vec_cnt++; if (active !== 1'b1 || timeout_err !== 1'b0) begin
         err_cnt++; $display("FAIL ack_wait: got active=%b err=%b expected 1 0", active, timeout_err);
      end
`endif
      req = 4'b0000;
      test_reset("final");
   endtask

   initial begin
      en       = 1'b1;
      req      = 4'b0000;
      req_data = 32'h0;
      tx_busy  = 1'b0;
      tx_done  = 1'b1;
      test_reset("reset");
      test_single_request();
      test_reset("reset2");
      test_all_requesting();
      test_not_ready();
      test_enable_freeze();
      test_reset_mid_frame();
      test_ack_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
